// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: entry layout, FSM states, trigger modes.
package trace_pkg;

    localparam int unsigned PKG_XLEN    = 32;
    localparam int unsigned PKG_RADDR_W = 5;

    // One retired instruction, MSB first: pc, inst, rd, wb_en, wb_data, mem_we
    typedef struct packed {
        logic [PKG_XLEN-1:0]    pc;
        logic [31:0]            inst;
        logic [PKG_RADDR_W-1:0] rd;
        logic                   wb_en;
        logic [PKG_XLEN-1:0]    wb_data;
        logic                   mem_we;
    } trace_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } tb_state_e;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'd0,
        TRIG_PC   = 2'd1,
        TRIG_INST = 2'd2,
        TRIG_EXT  = 2'd3
    } trig_mode_e;

    // Width of a packed trace entry for a given datapath and register index width
    function automatic int unsigned entry_w(input int unsigned xlen, input int unsigned raddr_w);
        return 2 * xlen + 32 + raddr_w + 2;
    endfunction

    localparam int unsigned ENTRY_W = entry_w(PKG_XLEN, PKG_RADDR_W);

endpackage

// File: rtl/trace_ram.sv
// Trace storage: simple dual-port, synchronous write, asynchronous read.
module trace_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 103,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: circular pre/post-trigger buffer drained oldest-first.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned POST_TRIG = 32,
    parameter int unsigned RADDR_W   = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          commit_valid,
    input  logic [XLEN-1:0]               commit_pc,
    input  logic [31:0]                   commit_inst,
    input  logic [RADDR_W-1:0]            commit_rd,
    input  logic                          commit_wb_en,
    input  logic [XLEN-1:0]               commit_wb_data,
    input  logic                          commit_mem_we,
    input  logic                          arm,
    input  logic                          abort,
    input  logic [1:0]                    trig_mode,
    input  logic [XLEN-1:0]               trig_pc,
    input  logic [31:0]                   trig_inst,
    input  logic [31:0]                   trig_mask,
    input  logic                          ext_trig,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*XLEN+32+RADDR_W+1:0]  out_data,
    output logic [1:0]                    state_o,
    output logic [$clog2(DEPTH):0]        fill_o,
    output logic                          done_pulse
);

    localparam int unsigned PTR_W        = $clog2(DEPTH);
    localparam int unsigned FILL_W       = PTR_W + 1;
    localparam int unsigned ENT_W        = entry_w(XLEN, RADDR_W);
    localparam bit          DIRECT_DRAIN = (POST_TRIG == 1);

    tb_state_e          r_state, w_nxt_state;
    logic [PTR_W-1:0]   r_wr_ptr, w_nxt_wr;
    logic [PTR_W-1:0]   r_rd_ptr, w_nxt_rd;
    logic [FILL_W-1:0]  r_fill, w_nxt_fill, w_fill_inc;
    logic [FILL_W-1:0]  r_post_cnt, w_nxt_post, w_post_inc;
    logic               r_out_valid, w_nxt_out_valid;
    logic [ENT_W-1:0]   r_out_data, w_nxt_out_data;
    logic               r_done, w_nxt_done;
    logic               w_we;
    logic               w_trig_hit;
    logic [ENT_W-1:0]   w_entry;
    logic [ENT_W-1:0]   w_rdata;
    logic [ENT_W-1:0]   w_rd_fwd;

    assign w_entry    = {commit_pc, commit_inst, commit_rd, commit_wb_en, commit_wb_data, commit_mem_we};
    assign w_fill_inc = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + FILL_W'(1);
    assign w_post_inc = r_post_cnt + FILL_W'(1);

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (r_wr_ptr),
        .i_wdata   (w_entry),
        .i_raddr   (w_nxt_rd),
        .o_rdata_c (w_rdata)
    );

    // A single-entry capture reads the slot being written on the same edge
    assign w_rd_fwd = (w_we && (r_wr_ptr == w_nxt_rd)) ? w_entry : w_rdata;

    // Trigger condition for the current commit
    always_comb begin
        w_trig_hit = 1'b0;
        case (trig_mode_e'(trig_mode))
            TRIG_IMM:  w_trig_hit = 1'b1;
            TRIG_PC:   w_trig_hit = (commit_pc == trig_pc);
            TRIG_INST: w_trig_hit = ((commit_inst & trig_mask) == (trig_inst & trig_mask));
            TRIG_EXT:  w_trig_hit = ext_trig;
            default:   w_trig_hit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state, pointer and counter update
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wr    = r_wr_ptr;
        w_nxt_rd    = r_rd_ptr;
        w_nxt_fill  = r_fill;
        w_nxt_post  = r_post_cnt;
        w_nxt_done  = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_nxt_state = ST_PRE;
                    w_nxt_wr    = '0;
                    w_nxt_fill  = '0;
                    w_nxt_post  = '0;
                end
            end
            ST_PRE: begin
                if (abort) begin
                    w_nxt_state = ST_IDLE;
                end else if (commit_valid) begin
                    w_we       = 1'b1;
                    w_nxt_wr   = r_wr_ptr + PTR_W'(1);
                    w_nxt_fill = w_fill_inc;
                    if (w_trig_hit) begin
                        w_nxt_post  = FILL_W'(1);
                        w_nxt_state = DIRECT_DRAIN ? ST_DRAIN : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (abort) begin
                    w_nxt_state = ST_IDLE;
                end else if (commit_valid) begin
                    w_we       = 1'b1;
                    w_nxt_wr   = r_wr_ptr + PTR_W'(1);
                    w_nxt_fill = w_fill_inc;
                    w_nxt_post = w_post_inc;
                    if (w_post_inc == FILL_W'(POST_TRIG)) begin
                        w_nxt_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_nxt_state = ST_IDLE;
                end else if (r_out_valid && out_ready) begin
                    w_nxt_rd   = r_rd_ptr + PTR_W'(1);
                    w_nxt_fill = r_fill - FILL_W'(1);
                    if (r_fill == FILL_W'(1)) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_done  = 1'b1;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        // Oldest surviving entry sits fill slots behind the write pointer
        if ((r_state != ST_DRAIN) && (w_nxt_state == ST_DRAIN)) begin
            w_nxt_rd = w_nxt_wr - w_nxt_fill[PTR_W-1:0];
        end
    end

    // Drain output next values; data holds whenever no new entry is presented
    always_comb begin
        w_nxt_out_valid = (w_nxt_state == ST_DRAIN) && (w_nxt_fill != '0);
        w_nxt_out_data  = w_nxt_out_valid ? w_rd_fwd : r_out_data;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_post_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_wr_ptr    <= w_nxt_wr;
            r_rd_ptr    <= w_nxt_rd;
            r_fill      <= w_nxt_fill;
            r_post_cnt  <= w_nxt_post;
            r_out_valid <= w_nxt_out_valid;
            r_out_data  <= w_nxt_out_data;
            r_done      <= w_nxt_done;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign state_o    = r_state;
    assign fill_o     = r_fill;
    assign done_pulse = r_done;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable on-FPGA retirement trace capture for the single-cycle RISC-V core; the hardware counterpart of the simulation per-cycle state dump.
- Records one entry per committed instruction into a circular buffer: PC, instruction, rd, writeback enable/data, MemRW.
- Capture stops a programmable number of entries after a trigger; the buffer is then drained oldest-first over a valid/ready stream.
- Sits beside the core top, fed from the core's PC, instruction, rd, writeback and MemRW signals.

Parameters:
- XLEN, 32, datapath width of PC and writeback data.
- DEPTH, 64, number of entries; power of two, minimum 4.
- POST_TRIG, 32, entries stored from the trigger onward, trigger entry included; 1 <= POST_TRIG <= DEPTH.
- RADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- commit_valid  in  1  an instruction retires this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- commit_inst  in  32  instruction word.
- commit_rd  in  RADDR_W  destination register.
- commit_wb_en  in  1  register write enable.
- commit_wb_data  in  XLEN  writeback value.
- commit_mem_we  in  1  MemRW.
- arm  in  1  single-cycle pulse; starts capture.
- abort  in  1  single-cycle pulse; returns the block to IDLE.
- trig_mode  in  2  0 = immediate, 1 = PC match, 2 = masked instruction match, 3 = external.
- trig_pc  in  XLEN  PC compare value.
- trig_inst, trig_mask  in  32 each  trigger when (commit_inst & trig_mask) == (trig_inst & trig_mask).
- ext_trig  in  1  external trigger, qualified by commit_valid.
- out_valid  out  1  a drain entry is available.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  2*XLEN+32+RADDR_W+2  packed trace_entry_t.
- state_o  out  2  current FSM state.
- fill_o  out  $clog2(DEPTH)+1  number of valid entries held.
- done_pulse  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (asynchronous, reset=0):
  - state IDLE; wr_ptr, fill, post_cnt and rd_ptr all 0.
  - out_valid=0, done_pulse=0, out_data=0.
- FSM states: IDLE, PRE, POST, DRAIN. Encoding is defined in the package.
- IDLE:
  - Commits are ignored.
  - arm=1 -> PRE; fill and wr_ptr are cleared that cycle.
- PRE:
  - Each commit_valid writes an entry at wr_ptr, then wr_ptr++ mod DEPTH and fill saturates at DEPTH.
  - When a valid commit meets the trigger condition, it is written, post_cnt=1, and the next state is POST.
  - If POST_TRIG==1, the next state is DRAIN directly.
  - Mode 0 triggers on the first valid commit after arm.
- POST:
  - Each commit_valid is written and post_cnt increments.
  - The write that makes post_cnt==POST_TRIG moves the FSM to DRAIN on the next edge.
  - Overwriting the oldest entries is permitted.
  - Trigger conditions are ignored.
- DRAIN:
  - rd_ptr = (wr_ptr - fill) mod DEPTH at entry.
  - out_valid=1 while remaining > 0; out_data = entry[rd_ptr].
  - out_data is stable while out_valid && !out_ready.
  - On out_valid && out_ready: rd_ptr++ and remaining--.
  - When the last entry is accepted: the next state is IDLE, done_pulse=1 for one cycle, and out_valid=0 in the following cycle.
  - Commits are ignored.
- abort in PRE, POST or DRAIN: IDLE next edge, out_valid=0, no done_pulse. abort has priority over arm in the same cycle.
- arm outside IDLE is ignored.
- Simultaneous arm and commit_valid in IDLE: the commit is not recorded.
- fill_o reports min(entries written since arm, DEPTH). In DRAIN it reports the entries remaining.
- Pointer wrap is modulo DEPTH with no gaps; the oldest entry is always overwritten first.

Decomposition:
- trace_pkg:
  - trace_entry_t packed struct in the order pc, inst, rd, wb_en, wb_data, mem_we (MSB first).
  - tb_state_e enum.
  - trig_mode_e enum.
  - ENTRY_W localparam function.
- Sub-module trace_ram:
  - Simple dual-port DEPTH x ENTRY_W.
  - Synchronous write, asynchronous read.
  - Instantiated once.

Test Plan (DEPTH=8, POST_TRIG=4):
- trig_mode=1, trig_pc=0x20, commits PC 0x00,0x04,... every cycle -> trigger on the 9th commit; drain yields exactly 8 entries, PC 0x10..0x2C ascending; done_pulse once.
- trig_mode=0, commit_valid on alternate cycles with PC 0x100,0x104,0x108,0x10C -> DRAIN after the 4th commit; fill_o=4; drain 0x100..0x10C.
- trig_mode=2, trig_inst=0x63, trig_mask=0x7F, stream of ADDI then 0x00208463 at PC 0x40 -> the trigger entry is 0x00208463; it is the 5th-from-last drained entry? No: with POST_TRIG=4 it is the 4th-from-last entry.
- Drain with out_ready pattern 1,0,1,0,... -> 8 distinct entries in order, no repeats or skips; out_data unchanged during stalls.
- reset driven low asynchronously mid-POST -> out_valid and state_o go to 0/IDLE without a clock edge; re-arm restarts with fill_o=0.
- abort during PRE after 3 commits -> IDLE with no done_pulse; arm plus 4 commits in mode 0 drains only the new 4 entries.
